// File: rtl/uart_rx_fsm.sv
// uart_rx_fsm: UART receive frame sequencer (start detect, oversample/bit counters,
// checker enables, frame verdict). Optional saturating error counter: UART_RX_ERR_CNT_EN.
module uart_rx_fsm #(
    parameter int IN_DATA_WIDTH = 8
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       RX_IN,
    input  logic       PAR_EN,
    input  logic [5:0] PRESCALE,
    input  logic       strt_glitch,
    input  logic       par_err,
    input  logic       stp_err,
    output logic [5:0] edge_cnt,
    output logic [3:0] bit_cnt,
    output logic       dat_samp_en,
    output logic       deser_en,
    output logic       strt_chk_en,
    output logic       par_chk_en,
    output logic       stp_chk_en,
    output logic       data_valid,
    output logic       frame_err,
    output logic [7:0] err_cnt
);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    localparam logic [3:0] LAST_BIT = 4'(IN_DATA_WIDTH - 1);

    state_t     state_reg, state_next;
    logic [5:0] edge_reg, edge_next;
    logic [3:0] bit_reg, bit_next;
    logic [5:0] p_reg, p_next;
    logic       pe_reg, pe_next;
    logic       samp_reg, samp_next;
    logic       deser_reg, deser_next;
    logic       strt_reg, strt_next;
    logic       parc_reg, parc_next;
    logic       stpc_reg, stpc_next;
    logic       dv_reg, dv_next;
    logic       fe_reg, fe_next;
    logic       last_edge;
    logic [5:0] cp;
    logic       at_cp;

    assign last_edge = (edge_reg == p_reg - 6'd1);

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_reg <= IDLE;
            edge_reg  <= '0;
            bit_reg   <= '0;
            p_reg     <= '0;
            pe_reg    <= 1'b0;
            samp_reg  <= 1'b0;
            deser_reg <= 1'b0;
            strt_reg  <= 1'b0;
            parc_reg  <= 1'b0;
            stpc_reg  <= 1'b0;
            dv_reg    <= 1'b0;
            fe_reg    <= 1'b0;
        end else begin
            state_reg <= state_next;
            edge_reg  <= edge_next;
            bit_reg   <= bit_next;
            p_reg     <= p_next;
            pe_reg    <= pe_next;
            samp_reg  <= samp_next;
            deser_reg <= deser_next;
            strt_reg  <= strt_next;
            parc_reg  <= parc_next;
            stpc_reg  <= stpc_next;
            dv_reg    <= dv_next;
            fe_reg    <= fe_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        edge_next  = '0;
        bit_next   = bit_reg;
        p_next     = p_reg;
        pe_next    = pe_reg;
        dv_next    = 1'b0;
        fe_next    = 1'b0;
        cp         = '0;
        at_cp      = 1'b0;
        samp_next  = 1'b0;
        deser_next = 1'b0;
        strt_next  = 1'b0;
        parc_next  = 1'b0;
        stpc_next  = 1'b0;

        if (state_reg != IDLE)
            edge_next = last_edge ? 6'd0 : edge_reg + 6'd1;

        case (state_reg)
            IDLE: begin
                if (!RX_IN) begin
                    state_next = START;
                    p_next     = PRESCALE;
                    pe_next    = 1'b0;
                end
            end
            START: begin
                if (last_edge) begin
                    if (strt_glitch) begin
                        state_next = IDLE;
                    end else begin
                        state_next = DATA;
                        bit_next   = '0;
                    end
                end
            end
            DATA: begin
                // bit index stays on the last bit once the data field is done
                if (last_edge) begin
                    if (bit_reg == LAST_BIT)
                        state_next = PAR_EN ? PARITY : STOP;
                    else
                        bit_next = bit_reg + 4'd1;
                end
            end
            PARITY: begin
                if (last_edge) begin
                    pe_next    = par_err;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (last_edge) begin
                    state_next = IDLE;
                    if (!stp_err && !pe_reg)
                        dv_next = 1'b1;
                    else
                        fe_next = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase

        // enables are registered, so decode them from the upcoming state and edge
        cp         = {1'b0, p_next[5:1]} + 6'd2;
        at_cp      = (edge_next == cp);
        samp_next  = (state_next != IDLE);
        strt_next  = (state_next == START)  && at_cp;
        deser_next = (state_next == DATA)   && at_cp;
        parc_next  = (state_next == PARITY) && at_cp;
        stpc_next  = (state_next == STOP)   && at_cp;
    end

    assign edge_cnt    = edge_reg;
    assign bit_cnt     = bit_reg;
    assign dat_samp_en = samp_reg;
    assign deser_en    = deser_reg;
    assign strt_chk_en = strt_reg;
    assign par_chk_en  = parc_reg;
    assign stp_chk_en  = stpc_reg;
    assign data_valid  = dv_reg;
    assign frame_err   = fe_reg;

`ifdef UART_RX_ERR_CNT_EN
    logic [7:0] err_reg;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST)
            err_reg <= '0;
        else if (fe_next && err_reg != 8'hFF)
            err_reg <= err_reg + 8'd1;
    end

    assign err_cnt = err_reg;
`else
    assign err_cnt = 8'd0;
`endif

endmodule

// File: tb/tb_uart_rx_fsm.sv
// Bench for uart_rx_fsm: directed frames with literal expectations plus random frames,
// all checked each cycle against a frame-offset arithmetic model.
`timescale 1ns/1ps
module tb_uart_rx_fsm;
    localparam int W = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx_in;
    logic       par_en;
    logic [5:0] prescale;
    logic       strt_glitch;
    logic       par_err;
    logic       stp_err;
    logic [5:0] edge_cnt;
    logic [3:0] bit_cnt;
    logic       dat_samp_en, deser_en, strt_chk_en, par_chk_en, stp_chk_en;
    logic       data_valid, frame_err;
    logic [7:0] err_cnt;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // model: frame position is just the cycle offset since start detect
    bit m_busy;
    int m_k, m_p, m_err;
    bit m_par, m_pe, m_dv, m_fe;

    // per-frame observations
    int st_dv_n, st_dv_at, st_fe_n, st_fe_at, st_deser_n, st_emin, st_emax;
    int st_par_n, st_stp_n, st_idle_at;

    logic [15:0] rd;
    bit          rpen, rgl, rpe, rse;
    int          rp;

    uart_rx_fsm #(.IN_DATA_WIDTH(W)) dut (
        .CLK(clk), .RST(rst), .RX_IN(rx_in), .PAR_EN(par_en), .PRESCALE(prescale),
        .strt_glitch(strt_glitch), .par_err(par_err), .stp_err(stp_err),
        .edge_cnt(edge_cnt), .bit_cnt(bit_cnt), .dat_samp_en(dat_samp_en),
        .deser_en(deser_en), .strt_chk_en(strt_chk_en), .par_chk_en(par_chk_en),
        .stp_chk_en(stp_chk_en), .data_valid(data_valid), .frame_err(frame_err),
        .err_cnt(err_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_busy = 0; m_k = 0; m_p = 0; m_err = 0;
        m_par = 0; m_pe = 0; m_dv = 0; m_fe = 0;
    endtask

    task automatic model_step();
        int seg, e;
        m_dv = 0;
        m_fe = 0;
        if (rst) begin
            model_reset();
        end else if (!m_busy) begin
            if (!rx_in) begin
                m_busy = 1; m_k = 1; m_p = int'(prescale); m_pe = 0;
            end
        end else begin
            seg = (m_k - 1) / m_p;
            e   = (m_k - 1) % m_p;
            if (e == m_p - 1) begin
                if (seg == 0 && strt_glitch) m_busy = 0;
                else if (seg == W) m_par = par_en;
                else if (seg == W + 1 && m_par) m_pe = par_err;
                if (m_busy && seg == W + 1 + (m_par ? 1 : 0)) begin
                    m_busy = 0;
                    if (!stp_err && !m_pe) m_dv = 1;
                    else begin
                        m_fe = 1;
                        if (m_err < 255) m_err++;
                    end
                end
            end
            m_k++;
        end
    endtask

    task automatic compare();
        int seg, e, cp, stop_seg, exp_err;
        seg = 0; e = 0; cp = 0;
        if (m_busy) begin
            seg = (m_k - 1) / m_p;
            e   = (m_k - 1) % m_p;
            cp  = m_p / 2 + 2;
        end
        stop_seg = W + 1 + (m_par ? 1 : 0);
`ifdef UART_RX_ERR_CNT_EN
        exp_err = m_err;
`else
        exp_err = 0;
`endif
        chk("edge_cnt", int'(edge_cnt), e);
        chk("dat_samp_en", int'(dat_samp_en), m_busy ? 1 : 0);
        chk("strt_chk_en", int'(strt_chk_en), (m_busy && seg == 0 && e == cp) ? 1 : 0);
        chk("deser_en", int'(deser_en), (m_busy && seg >= 1 && seg <= W && e == cp) ? 1 : 0);
        chk("par_chk_en", int'(par_chk_en), (m_busy && m_par && seg == W + 1 && e == cp) ? 1 : 0);
        chk("stp_chk_en", int'(stp_chk_en), (m_busy && seg == stop_seg && e == cp) ? 1 : 0);
        chk("data_valid", int'(data_valid), m_dv ? 1 : 0);
        chk("frame_err", int'(frame_err), m_fe ? 1 : 0);
        chk("err_cnt", int'(err_cnt), exp_err);
        if (m_busy && seg >= 1 && seg <= W)
            chk("bit_cnt", int'(bit_cnt), seg - 1);
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        cyc++;
        compare();
    endtask

    task automatic idle(input int n);
        rx_in = 1'b1;
        repeat (n) tick();
    endtask

    function automatic logic line_level(input int c, input logic [15:0] d, input bit pen,
                                        input int p, input bit gl);
        int   seg;
        logic par;
        if (gl) return (c < 2) ? 1'b0 : 1'b1;
        if (c == 0) return 1'b0;
        seg = (c - 1) / p;
        if (seg == 0) return 1'b0;
        if (seg <= W) return d[seg-1];
        par = 1'b0;
        for (int i = 0; i < W; i++) par ^= d[i];
        if (pen && seg == W + 1) return par;
        return 1'b1;
    endfunction

    task automatic observe(input int c);
        if (data_valid) begin st_dv_n++; st_dv_at = c; end
        if (frame_err)  begin st_fe_n++; st_fe_at = c; end
        if (deser_en) begin
            st_deser_n++;
            if (int'(edge_cnt) < st_emin) st_emin = int'(edge_cnt);
            if (int'(edge_cnt) > st_emax) st_emax = int'(edge_cnt);
        end
        if (par_chk_en) st_par_n++;
        if (stp_chk_en) st_stp_n++;
        if (!dat_samp_en && st_idle_at < 0) st_idle_at = c;
    endtask

    // mid_kind: 0 none, 1 reset at data bit 4, 2 PRESCALE->32 at data bit 4
    task automatic drive_frame(input logic [15:0] d, input bit pen, input int p, input bit gl,
                               input bit pe, input bit se, input int mid_kind);
        int n, len, t0;
        n   = W + 2 + (pen ? 1 : 0);
        len = gl ? p + 1 : n * p + 1;
        st_dv_n = 0; st_dv_at = -1; st_fe_n = 0; st_fe_at = -1; st_deser_n = 0;
        st_emin = 99; st_emax = -1; st_par_n = 0; st_stp_n = 0; st_idle_at = -1;
        par_en = pen; prescale = 6'(p); strt_glitch = gl; par_err = pe; stp_err = se;
        t0 = cyc;
        for (int c = 0; c < len; c++) begin
            if (mid_kind != 0 && c == 5 * p + 1) begin
                if (mid_kind == 2) begin
                    prescale = 6'd32;
                end else begin
                    rst = 1'b1;
                    model_reset();
                    rx_in = 1'b1;
                    #1;
                    chk("rst_async_samp", int'(dat_samp_en), 0);
                    chk("rst_async_edge", int'(edge_cnt), 0);
                    tick();
                    chk("rst_next_samp", int'(dat_samp_en), 0);
                    chk("rst_next_edge", int'(edge_cnt), 0);
                    chk("rst_next_bit", int'(bit_cnt), 0);
                    chk("rst_next_valid", int'(data_valid | frame_err), 0);
                    chk("rst_next_err_cnt", int'(err_cnt), 0);
                    rst = 1'b0;
                    $display("frame data=%h P=%0d par=%0d aborted by reset", d, p, pen);
                    return;
                end
            end
            rx_in = line_level(c, d, pen, p, gl);
            tick();
            observe(cyc - t0);
        end
        $display("frame data=%h P=%0d par=%0d glitch=%0d pe=%0d se=%0d valid_at=%0d err_at=%0d",
                 d, p, pen, gl, pe, se, st_dv_at, st_fe_at);
    endtask

    initial begin
        rst = 1'b1; rx_in = 1'b1; par_en = 1'b0; prescale = 6'd8;
        strt_glitch = 1'b0; par_err = 1'b0; stp_err = 1'b0;
        model_reset();
        repeat (3) tick();
        chk("reset_edge", int'(edge_cnt), 0);
        chk("reset_bit", int'(bit_cnt), 0);
        chk("reset_samp", int'(dat_samp_en), 0);
        chk("reset_valid", int'(data_valid), 0);
        chk("reset_ferr", int'(frame_err), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        rst = 1'b0;
        idle(2);

        // clean frame 0xA5, P=8, parity present (even parity of 0xA5 is 0)
        drive_frame(16'h00A5, 1, 8, 0, 0, 0, 0);
        chk("clean_valid_cycle", st_dv_at, 89);
        chk("clean_valid_count", st_dv_n, 1);
        chk("clean_ferr_count", st_fe_n, 0);
        chk("clean_deser_count", st_deser_n, 8);
        chk("clean_deser_edge_min", st_emin, 6);
        chk("clean_deser_edge_max", st_emax, 6);
        chk("clean_par_chk_count", st_par_n, 1);
        idle(1);
        chk("clean_valid_width", int'(data_valid), 0);

        // start glitch
        drive_frame(16'h0000, 1, 8, 1, 0, 0, 0);
        chk("glitch_idle_cycle", st_idle_at, 9);
        chk("glitch_deser_count", st_deser_n, 0);
        chk("glitch_valid_count", st_dv_n, 0);
        chk("glitch_ferr_count", st_fe_n, 0);
        idle(2);

        // parity error
        drive_frame(16'h003C, 1, 8, 0, 1, 0, 0);
        chk("parity_ferr_cycle", st_fe_at, 89);
        chk("parity_ferr_count", st_fe_n, 1);
        chk("parity_valid_count", st_dv_n, 0);
        chk("parity_stop_seen", st_stp_n, 1);
`ifdef UART_RX_ERR_CNT_EN
        chk("parity_err_cnt", int'(err_cnt), 1);
`else
        chk("parity_err_cnt", int'(err_cnt), 0);
`endif
        idle(3);

        // no parity, P=16
        drive_frame(16'h005A, 0, 16, 0, 0, 0, 0);
        chk("nopar_valid_cycle", st_dv_at, 161);
        chk("nopar_valid_count", st_dv_n, 1);
        chk("nopar_par_chk_count", st_par_n, 0);

        // back-to-back: PRESCALE changed to 32 mid-frame is ignored
        drive_frame(16'h00C3, 1, 8, 0, 0, 0, 2);
        chk("presc_valid_cycle", st_dv_at, 89);
        chk("presc_valid_count", st_dv_n, 1);
        idle(2);

        // reset mid-frame, then a clean frame
        drive_frame(16'h0081, 1, 8, 0, 0, 0, 1);
        idle(2);
        drive_frame(16'h00A5, 1, 8, 0, 0, 0, 0);
        chk("after_rst_valid_cycle", st_dv_at, 89);
        chk("after_rst_valid_count", st_dv_n, 1);

        for (int i = 0; i < 40; i++) begin
            rd   = 16'($urandom);
            rpen = 1'($urandom_range(0, 1));
            rp   = 2 * int'($urandom_range(4, 16));
            rgl  = ($urandom_range(0, 7) == 0);
            rpe  = ($urandom_range(0, 3) == 0);
            rse  = ($urandom_range(0, 3) == 0);
            drive_frame(rd, rpen, rp, rgl, rpe, rse, 0);
            idle(int'($urandom_range(0, 3)));
        end

`ifdef UART_RX_ERR_CNT_EN
        for (int i = 0; i < 260; i++)
            drive_frame(16'(i), 0, 8, 0, 0, 1, 0);
        idle(1);
        chk("sat_err_cnt", int'(err_cnt), 255);
`endif

        idle(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
